pc_sequencer: RTL

Program-counter and control-flow stage of the single-cycle 16-bit CPU. It sits directly downstream of the ALU: it consumes the ALU's ZERO flag to resolve conditional branches, and produces the PC that drives instruction fetch. It also holds a small hardware return-address stack for CALL/RET, and a run/halt/fault state machine.

---
 rtl/pc_sequencer.sv | 76 +++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, conditional branch resolution, return-address stack
// and run/halt/fault control for the single-cycle 16-bit CPU.
module pc_sequencer #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH,
    input  logic        ZERO,
    input  logic [7:0]  OFFSET,
    input  logic        JUMP,
    input  logic        CALL,
    input  logic        RET,
    input  logic [15:0] TARGET,
    input  logic        HALT,
    input  logic        RESUME,
    output logic [15:0] PC,
    output logic [4:0]  DEPTH_OUT,
    output logic        HALTED,
    output logic        FAULT
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {st_run, st_halted, st_faulted} state_t;

    state_t      state;
    logic [15:0] stack [DEPTH];
    logic [15:0] pc_inc, top, br_target;
    logic        empty, full, push;

    assign pc_inc    = PC + 16'd1;
    assign br_target = pc_inc + {{8{OFFSET[7]}}, OFFSET};
    assign top       = stack[AW'(DEPTH_OUT - 5'd1)];
    assign empty     = DEPTH_OUT == 5'd0;
    assign full      = DEPTH_OUT == 5'(DEPTH);
    assign push      = state == st_run && !RESET && !STALL && !HALT && CALL && !RET && !full;
    assign HALTED    = state == st_halted;
    assign FAULT     = state == st_faulted;

    // Stack contents carry no reset; the write pointer is the depth register.
    always_ff @(posedge CLK)
        if (push) stack[DEPTH_OUT[AW-1:0]] <= pc_inc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= st_run;
            PC        <= RESET_PC;
            DEPTH_OUT <= 5'd0;
        end else if (!STALL) begin
            case (state)
                st_run: begin
                    if (HALT) state <= st_halted;
                    else if (CALL && RET) state <= st_faulted;
                    else if (RET) begin
                        if (empty) state <= st_faulted;
                        else begin
                            PC        <= top;
                            DEPTH_OUT <= DEPTH_OUT - 5'd1;
                        end
                    end else if (CALL) begin
                        if (full) state <= st_faulted;
                        else begin
                            PC        <= TARGET;
                            DEPTH_OUT <= DEPTH_OUT + 5'd1;
                        end
                    end else if (JUMP) PC <= TARGET;
                    else PC <= (BRANCH && ZERO) ? br_target : pc_inc;
                end
                st_halted: if (RESUME) state <= st_run;
                default: ;
            endcase
        end
    end
endmodule
